unified_mem_ctrl: RTL

UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

---
 rtl/unified_mem_ctrl_pkg.sv | 12 +
 rtl/unified_mem_ctrl_align.sv | 38 +++
 rtl/unified_mem_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/unified_mem_ctrl_pkg.sv
// unified_mem_ctrl_pkg: RV32 load/store funct3 codes and controller FSM encoding.
package unified_mem_ctrl_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
endpackage

// File: rtl/unified_mem_ctrl_align.sv
// mem_lane_align: byte-lane steering for stores, extract/extend for loads, access legality.
module mem_lane_align
    import unified_mem_ctrl_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        err
);
    logic [4:0]  sh;
    logic [15:0] rh;
    always_comb begin
        sh = {addr_lo, 3'b000};
        rh = 16'(rword >> sh);
        case (funct3)
            F3_LB:   err = 1'b0;
            F3_LH:   err = addr_lo[0];
            F3_LW:   err = addr_lo != 2'b00;
            F3_LBU:  err = we;
            F3_LHU:  err = we | addr_lo[0];
            default: err = 1'b1;
        endcase
        be = !we || err ? 4'b0000
           : funct3 == F3_SB ? 4'b0001 << addr_lo
           : funct3 == F3_SH ? 4'b0011 << {addr_lo[1], 1'b0}
           : funct3 == F3_SW ? 4'b1111 : 4'b0000;
        wword = wdata << sh;
        rdata = funct3 == F3_LB  ? {{24{rh[7]}}, rh[7:0]}
              : funct3 == F3_LH  ? {{16{rh[15]}}, rh}
              : funct3 == F3_LBU ? {24'd0, rh[7:0]}
              : funct3 == F3_LHU ? {16'd0, rh} : rword;
    end
endmodule

// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: single-ported word memory shared by a fetch port and a load/store port.
// One access in flight at a time; the data port wins simultaneous requests.
module unified_mem_ctrl
    import unified_mem_ctrl_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    state_t state, nstate;
    logic [3:0] cnt;
    logic port_d, we_q;
    logic [2:0] f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0] wdata_q;
    logic a_d, a_we;
    logic [2:0] a_f3;
    logic [AW+1:0] a_addr;
    logic [31:0] a_wdata;
    logic accept, enter_resp;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rword, wword, rdata;
    logic [3:0] be;
    logic err;
    logic unused_bits;

    assign unused_bits = ^{i_addr[31:AW+2], d_addr[31:AW+2]};

    // In IDLE the access is described by the ports (so zero-wait accesses work); afterwards by the latches.
    always_comb begin
        a_d     = state == S_IDLE ? d_req : port_d;
        a_we    = state == S_IDLE ? d_req & d_we : we_q;
        a_f3    = state == S_IDLE ? (d_req ? d_funct3 : F3_LW) : f3_q;
        a_addr  = state == S_IDLE ? (d_req ? d_addr[AW+1:0] : i_addr[AW+1:0]) : addr_q;
        a_wdata = state == S_IDLE ? d_wdata : wdata_q;
    end

    assign rword = mem[a_addr[AW+1:2]];

    mem_lane_align u_align (
        .we     (a_we),
        .funct3 (a_f3),
        .addr_lo(a_addr[1:0]),
        .wdata  (a_wdata),
        .rword  (rword),
        .be     (be),
        .wword  (wword),
        .rdata  (rdata),
        .err    (err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  nstate = accept ? (WAIT_CYCLES > 0 ? S_WAIT : S_RESP) : S_IDLE;
            S_WAIT:  nstate = cnt == W_LAST ? S_RESP : S_WAIT;
            default: nstate = S_IDLE;
        endcase
    end

    always_comb begin
        d_gnt    = d_req & (state == S_IDLE) & rst;
        i_gnt    = i_req & ~d_req & (state == S_IDLE) & rst;
        busy     = state != S_IDLE;
        d_rvalid = (state == S_RESP) & port_d;
        i_rvalid = (state == S_RESP) & ~port_d;
    end

    assign accept     = d_gnt | i_gnt;
    assign enter_resp = nstate == S_RESP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            port_d  <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            i_rdata <= '0;
            i_err   <= 1'b0;
            d_rdata <= '0;
            d_err   <= 1'b0;
        end else begin
            cnt <= state == S_WAIT ? cnt + 4'd1 : 4'd0;
            if (accept) begin
                port_d  <= a_d;
                we_q    <= a_we;
                f3_q    <= a_f3;
                addr_q  <= a_addr;
                wdata_q <= a_wdata;
            end
            if (enter_resp && a_d) begin
                d_rdata <= err || a_we ? 32'd0 : rdata;
                d_err   <= err;
            end
            if (enter_resp && !a_d) begin
                i_rdata <= err ? 32'd0 : rdata;
                i_err   <= err;
            end
        end
    end

    // Array is deliberately not reset; writes land on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (enter_resp)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[a_addr[AW+1:2]][8*b +: 8] <= wword[8*b +: 8];
    end
endmodule
